// File: rtl/seq_mem_arb_pkg.sv
// Shared types for the two-requester sequential memory arbiter.
//   state_t  : arbiter FSM states.
//   owner_t  : which requester owns the access in flight or was granted last.
//   LAST_RST : reset value of the round-robin pointer. It is B, so A wins the first tie.
package seq_mem_arb_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    typedef enum logic {OWN_A, OWN_B} owner_t;

    localparam owner_t LAST_RST = OWN_B;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
//   valid_a, valid_b : requests present
//   last             : 1 when B was granted most recently, 0 when A was
//   grant_a, grant_b : one-hot grant, or zero when nothing is valid
module rr_pick2
    import seq_mem_arb_pkg::*;
(
    input  logic valid_a,
    input  logic valid_b,
    input  logic last,
    output logic grant_a,
    output logic grant_b
);

    logic last_is_b;

    assign last_is_b = (last == OWN_B);

    // A lone requester always wins. On a tie, the requester that was not last wins.
    assign grant_a = valid_a & (~valid_b | last_is_b);
    assign grant_b = valid_b & (~valid_a | ~last_is_b);

endmodule

// File: rtl/seq_mem_arbiter_2.sv
// Round-robin arbiter that shares one single-port sequential memory between
// requesters A and B. Each access takes one grant cycle and one wait cycle.
// The response is registered and appears two cycles after the grant.
// Out-of-range addresses get an error response and never reach the memory.
//   clk, reset (async, active-low)
//   a_/b_req_*  : valid/ready request handshake, carrying write flag, address and write data
//   a_/b_resp_* : one-cycle response pulse with read data and error flag
//   mem_*       : memory command outputs (addr, data, enables) and completion inputs
module seq_mem_arbiter_2
    import seq_mem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 4,
    parameter int IDX_SIZE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_req_valid,
    output logic                a_req_ready,
    input  logic                a_req_write,
    input  logic [IDX_SIZE-1:0] a_req_addr,
    input  logic [WIDTH-1:0]    a_req_wdata,
    output logic                a_resp_valid,
    output logic [WIDTH-1:0]    a_resp_rdata,
    output logic                a_resp_err,
    input  logic                b_req_valid,
    output logic                b_req_ready,
    input  logic                b_req_write,
    input  logic [IDX_SIZE-1:0] b_req_addr,
    input  logic [WIDTH-1:0]    b_req_wdata,
    output logic                b_resp_valid,
    output logic [WIDTH-1:0]    b_resp_rdata,
    output logic                b_resp_err,
    output logic [IDX_SIZE-1:0] mem_addr0,
    output logic                mem_read_en,
    output logic                mem_write_en,
    output logic [WIDTH-1:0]    mem_in,
    input  logic [WIDTH-1:0]    mem_out,
    input  logic                mem_read_done,
    input  logic                mem_write_done
);

    localparam logic [IDX_SIZE:0] SIZE_W = (IDX_SIZE + 1)'(SIZE);

    state_t state_q, state_d;
    owner_t last_q, own_q, sel_owner;
    logic   wr_q, oob_q;
    logic   grant_a, grant_b, last_b;
    logic   granted, done;
    logic   sel_write, sel_oob;
    logic [IDX_SIZE-1:0] sel_addr;
    logic [WIDTH-1:0]    sel_wdata;

    assign last_b = (last_q == OWN_B);

    rr_pick2 u_pick (
        .valid_a (a_req_valid),
        .valid_b (b_req_valid),
        .last    (last_b),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // The picker's grant is one-hot, so B's fields are used exactly when B wins.
    assign sel_owner = grant_b ? OWN_B : OWN_A;
    assign sel_write = grant_b ? b_req_write : a_req_write;
    assign sel_addr  = grant_b ? b_req_addr  : a_req_addr;
    assign sel_wdata = grant_b ? b_req_wdata : a_req_wdata;
    assign sel_oob   = ({1'b0, sel_addr} >= SIZE_W);

    always_comb begin
        state_d      = state_q;
        granted      = 1'b0;
        done         = 1'b0;
        a_req_ready  = 1'b0;
        b_req_ready  = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        mem_addr0    = '0;
        mem_in       = '0;
        case (state_q)
            IDLE: begin
                // Reset is checked here as well. The combinational ready and
                // strobe outputs must stay low while reset is held.
                if (reset && (grant_a || grant_b)) begin
                    granted     = 1'b1;
                    a_req_ready = grant_a;
                    b_req_ready = grant_b;
                    if (!sel_oob) begin
                        mem_addr0    = sel_addr;
                        mem_in       = sel_wdata;
                        mem_write_en = sel_write;
                        mem_read_en  = ~sel_write;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Only the done that matches the captured op completes the access.
                if (oob_q || (wr_q ? mem_write_done : mem_read_done)) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant capture and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_q       <= LAST_RST;
            own_q        <= OWN_A;
            wr_q         <= 1'b0;
            oob_q        <= 1'b0;
            a_resp_valid <= 1'b0;
            a_resp_err   <= 1'b0;
            a_resp_rdata <= '0;
            b_resp_valid <= 1'b0;
            b_resp_err   <= 1'b0;
            b_resp_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (granted) begin
                last_q <= sel_owner;
                own_q  <= sel_owner;
                wr_q   <= sel_write;
                oob_q  <= sel_oob;
            end
            a_resp_valid <= done && (own_q == OWN_A);
            a_resp_err   <= done && (own_q == OWN_A) && oob_q;
            a_resp_rdata <= (done && (own_q == OWN_A) && !oob_q && !wr_q) ? mem_out : '0;
            b_resp_valid <= done && (own_q == OWN_B);
            b_resp_err   <= done && (own_q == OWN_B) && oob_q;
            b_resp_rdata <= (done && (own_q == OWN_B) && !oob_q && !wr_q) ? mem_out : '0;
        end
    end

endmodule

// File: tb/tb_seq_mem_arbiter_2.sv
module tb_seq_mem_arbiter_2;

    localparam int WIDTH    = 32;
    localparam int SIZE     = 4;
    localparam int IDX_SIZE = 4;

    logic                clk;
    logic                reset;
    logic                a_req_valid, a_req_ready, a_req_write;
    logic [IDX_SIZE-1:0] a_req_addr;
    logic [WIDTH-1:0]    a_req_wdata;
    logic                a_resp_valid, a_resp_err;
    logic [WIDTH-1:0]    a_resp_rdata;
    logic                b_req_valid, b_req_ready, b_req_write;
    logic [IDX_SIZE-1:0] b_req_addr;
    logic [WIDTH-1:0]    b_req_wdata;
    logic                b_resp_valid, b_resp_err;
    logic [WIDTH-1:0]    b_resp_rdata;
    logic [IDX_SIZE-1:0] mem_addr0;
    logic                mem_read_en, mem_write_en;
    logic [WIDTH-1:0]    mem_in;
    logic [WIDTH-1:0]    mem_out = '0;
    logic                mem_read_done = 1'b0;
    logic                mem_write_done = 1'b0;

    seq_mem_arbiter_2 #(.WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE)) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_resp_valid(a_resp_valid), .a_resp_rdata(a_resp_rdata), .a_resp_err(a_resp_err),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_resp_valid(b_resp_valid), .b_resp_rdata(b_resp_rdata), .b_resp_err(b_resp_err),
        .mem_addr0(mem_addr0), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_in(mem_in), .mem_out(mem_out),
        .mem_read_done(mem_read_done), .mem_write_done(mem_write_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory device: one-cycle access, registered done and read data.
    logic [WIDTH-1:0] dev_mem [SIZE];
    always @(posedge clk) begin
        mem_read_done  <= mem_read_en;
        mem_write_done <= mem_write_en;
        if (mem_write_en) dev_mem[mem_addr0[1:0]] <= mem_in;
        if (mem_read_en)  mem_out <= dev_mem[mem_addr0[1:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model. An access occupies the arbiter for two cycles. The
    // response is due two cycles after the grant. Ties go to whichever
    // requester was not granted last.
    typedef struct {
        int           due;
        bit           own_b;
        logic [31:0]  rdata;
        bit           err;
    } resp_t;

    resp_t       pend[$];
    logic [31:0] ref_mem [SIZE];
    int          free_cyc = 0;
    bit          last_b = 1'b1;
    bit          a_acc = 1'b0, b_acc = 1'b0;
    int          a_acc_cyc = 0, b_acc_cyc = 0;

    always @(negedge clk) begin
        bit          ega, egb, w, oob, erd, ewr;
        bit          eav, ebv, eae, ebe;
        logic [31:0] ear, ebr, d;
        int          ad;
        a_acc = a_req_ready;
        b_acc = b_req_ready;
        if (a_acc) a_acc_cyc = cyc;
        if (b_acc) b_acc_cyc = cyc;
        if (!reset) begin
            check_eq("reset_outputs",
                     64'({a_req_ready, b_req_ready, a_resp_valid, b_resp_valid, a_resp_err, b_resp_err,
                          mem_read_en, mem_write_en, |a_resp_rdata, |b_resp_rdata, |mem_addr0, |mem_in}),
                     64'(0));
            pend.delete();
            free_cyc = 0;
            last_b   = 1'b1;
        end else begin
            ega = 0; egb = 0; erd = 0; ewr = 0;
            if (cyc >= free_cyc) begin
                if (a_req_valid && b_req_valid) begin
                    ega = last_b;
                    egb = !last_b;
                end else begin
                    ega = a_req_valid;
                    egb = b_req_valid;
                end
            end
            check_eq("a_ready", 64'(a_req_ready), 64'(ega));
            check_eq("b_ready", 64'(b_req_ready), 64'(egb));
            check_eq("rd_wr_mutex", 64'(mem_read_en & mem_write_en), 64'(0));
            if (ega || egb) begin
                w   = egb ? b_req_write : a_req_write;
                ad  = egb ? int'(b_req_addr) : int'(a_req_addr);
                d   = egb ? b_req_wdata : a_req_wdata;
                oob = (ad >= SIZE);
                if (!oob) begin
                    ewr = w;
                    erd = !w;
                end
                pend.push_back('{due: cyc + 2, own_b: egb,
                                 rdata: (w || oob) ? 32'd0 : ref_mem[ad], err: oob});
                if (w && !oob) ref_mem[ad] = d;
                free_cyc = cyc + 2;
                last_b   = egb;
                if (erd || ewr) begin
                    check_eq("mem_addr0", 64'(mem_addr0), 64'(ad));
                    check_eq("mem_in", 64'(mem_in), 64'(d));
                end
            end
            check_eq("mem_read_en", 64'(mem_read_en), 64'(erd));
            check_eq("mem_write_en", 64'(mem_write_en), 64'(ewr));
            eav = 0; ebv = 0; eae = 0; ebe = 0; ear = 0; ebr = 0;
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                if (pend[0].own_b) begin
                    ebv = 1; ebr = pend[0].rdata; ebe = pend[0].err;
                end else begin
                    eav = 1; ear = pend[0].rdata; eae = pend[0].err;
                end
                void'(pend.pop_front());
            end
            check_eq("a_resp_valid", 64'(a_resp_valid), 64'(eav));
            check_eq("a_resp_rdata", 64'(a_resp_rdata), 64'(ear));
            check_eq("a_resp_err", 64'(a_resp_err), 64'(eae));
            check_eq("b_resp_valid", 64'(b_resp_valid), 64'(ebv));
            check_eq("b_resp_rdata", 64'(b_resp_rdata), 64'(ebr));
            check_eq("b_resp_err", 64'(b_resp_err), 64'(ebe));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit is_b, input bit v, input bit w,
                           input logic [IDX_SIZE-1:0] ad, input logic [WIDTH-1:0] d);
        if (is_b) begin
            b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wdata = d;
        end else begin
            a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wdata = d;
        end
    endtask

    // Issues one request and waits, within a bounded number of cycles, for its response.
    task automatic xfer(input bit is_b, input bit w, input logic [IDX_SIZE-1:0] ad,
                        input logic [WIDTH-1:0] d, output logic [WIDTH-1:0] rd,
                        output bit err, output bit got, output int lat);
        int acc_at;
        bit acc;
        rd = 0; err = 0; got = 0; lat = -1; acc = 0; acc_at = 0;
        set_req(is_b, 1, w, ad, d);
        for (int i = 0; i < 10; i++) begin
            step();
            if (is_b ? b_acc : a_acc) begin
                acc = 1;
                acc_at = is_b ? b_acc_cyc : a_acc_cyc;
                break;
            end
        end
        set_req(is_b, 0, 0, '0, '0);
        if (acc) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (is_b ? b_resp_valid : a_resp_valid) begin
                    got = 1;
                    rd  = is_b ? b_resp_rdata : a_resp_rdata;
                    err = is_b ? b_resp_err : a_resp_err;
                    lat = cyc - acc_at;
                    break;
                end
            end
            #1;
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        bit   err, got, last_own, prev_own;
        int   lat, grants, nxt;
        int   acc_cycles[4];
        logic [IDX_SIZE-1:0] nxt_addr;

        for (int i = 0; i < SIZE; i++) ref_mem[i] = 0;
        reset = 0;
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        step(); step(); step();
        reset = 1;
        step();

        // Single write then read on A
        xfer(0, 1, 4'd2, 32'hDEADBEEF, rd, err, got, lat);
        check_eq("t1_wr_resp_seen", 64'(got), 64'(1));
        check_eq("t1_wr_latency", 64'(lat), 64'(2));
        step();
        xfer(0, 0, 4'd2, 32'h0, rd, err, got, lat);
        check_eq("t1_rd_resp_seen", 64'(got), 64'(1));
        check_eq("t1_rd_rdata", 64'(rd), 64'(32'hDEADBEEF));
        check_eq("t1_rd_err", 64'(err), 64'(0));
        check_eq("t1_rd_latency", 64'(lat), 64'(2));
        step();

        // Back-to-back writes from A to addresses 0..3
        nxt = 0;
        set_req(0, 1, 1, 4'd0, $urandom);
        for (int i = 0; i < 20 && nxt < 4; i++) begin
            step();
            if (a_acc) begin
                acc_cycles[nxt] = a_acc_cyc;
                nxt++;
                if (nxt < 4) set_req(0, 1, 1, 4'(nxt), $urandom);
                else set_req(0, 0, 0, '0, '0);
            end
        end
        set_req(0, 0, 0, '0, '0);
        check_eq("t6_grant_count", 64'(nxt), 64'(4));
        for (int i = 1; i < 4; i++)
            check_eq("t6_grant_spacing", 64'(acc_cycles[i] - acc_cycles[i-1]), 64'(2));
        step(); step(); step();

        // Tie fairness: both hold valid for 8 grants
        grants = 0;
        prev_own = 0;
        set_req(0, 1, $urandom_range(0, 1), 4'($urandom_range(0, 3)), $urandom);
        set_req(1, 1, $urandom_range(0, 1), 4'($urandom_range(0, 3)), $urandom);
        for (int i = 0; i < 40 && grants < 8; i++) begin
            step();
            if (a_acc || b_acc) begin
                last_own = b_acc;
                if (grants > 0) check_eq("t2_alternate", 64'(last_own), 64'(!prev_own));
                prev_own = last_own;
                grants++;
                if (a_acc) set_req(0, 1, $urandom_range(0, 1), 4'($urandom_range(0, 3)), $urandom);
                if (b_acc) set_req(1, 1, $urandom_range(0, 1), 4'($urandom_range(0, 3)), $urandom);
            end
        end
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        check_eq("t2_grant_count", 64'(grants), 64'(8));
        step(); step(); step();

        // Out-of-range read from B
        xfer(1, 0, 4'd7, 32'h0, rd, err, got, lat);
        check_eq("t3_resp_seen", 64'(got), 64'(1));
        check_eq("t3_err", 64'(err), 64'(1));
        check_eq("t3_rdata", 64'(rd), 64'(0));
        check_eq("t3_latency", 64'(lat), 64'(2));
        step();

        // Random traffic from both requesters, some out of range
        for (int i = 0; i < 200; i++) begin
            step();
            if (!a_req_valid || a_acc)
                set_req(0, ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                        4'($urandom_range(0, 5)), $urandom);
            if (!b_req_valid || b_acc)
                set_req(1, ($urandom_range(0, 2) != 0), $urandom_range(0, 1),
                        4'($urandom_range(0, 5)), $urandom);
        end
        set_req(0, 0, 0, '0, '0);
        set_req(1, 0, 0, '0, '0);
        for (int i = 0; i < 4; i++) step();

        // Reset one cycle after A's read is accepted
        got = 0;
        set_req(0, 1, 0, 4'd1, '0);
        for (int i = 0; i < 10; i++) begin
            step();
            if (a_acc) begin
                got = 1;
                break;
            end
        end
        check_eq("t5_accepted", 64'(got), 64'(1));
        reset = 0;
        set_req(0, 0, 0, '0, '0);
        step(); step();
        reset = 1;
        step(); step(); step();
        set_req(0, 1, 0, 4'd0, '0);
        set_req(1, 1, 0, 4'd1, '0);
        step();
        check_eq("t5_tie_to_a", 64'(a_acc), 64'(1));
        check_eq("t5_tie_not_b", 64'(b_acc), 64'(0));
        set_req(0, 0, 0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            step();
            if (b_acc) set_req(1, 0, 0, '0, '0);
        end
        set_req(1, 0, 0, '0, '0);
        step(); step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
